// File: rtl/dsm_mod_param.sv
// dsm_mod_param: parametrised delta-sigma modulator, order 1 or 2 (CIFB),
// 1..4-bit quantizer with power-of-two feedback levels.
// The loop advances one step per oversampling tick (ce). A new input sample
// is taken from a one-deep valid/ready buffer every 2^OSR_LOG2 ticks.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   ce              oversampling tick; loop state advances only when high
//   in_data         signed input sample (DW bits)
//   in_valid        sample offered
//   in_ready        buffer free
//   clr_flags       clears both sticky flags (a set in the same cycle wins)
//   code            quantizer code (QBITS bits); for QBITS=1 this is the pwm bit
//   code_valid      registered copy of ce; pulses one cycle after each tick
//   sat_flag        sticky: an integrator clipped
//   underrun        sticky: buffer was empty at a sample boundary
module dsm_mod_param #(
  parameter int DW       = 20,
  parameter int IW       = 24,
  parameter int ORDER    = 1,
  parameter int QBITS    = 1,
  parameter int OSR_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr_flags,
  output logic [QBITS-1:0] code,
  output logic             code_valid,
  output logic             sat_flag,
  output logic             underrun
);

  localparam int L   = 1 << QBITS;
  localparam int FSL = DW - 5;            // log2 of full scale
  localparam int QSH = FSL - QBITS + 1;   // quantizer shift
  localparam int OSR = 1 << OSR_LOG2;
  localparam int CW  = (OSR_LOG2 > 0) ? OSR_LOG2 : 1;
  localparam int MW  = (IW > DW) ? IW : DW;
  localparam int EW  = MW + 3;            // headroom for i + x - fb without wrap

  localparam logic signed [IW-1:0] IMAX = {1'b0, {(IW-1){1'b1}}};
  localparam logic signed [IW-1:0] IMIN = {1'b1, {(IW-1){1'b0}}};

  logic signed [IW-1:0]    i1, i2, i1n, i2n, s, qf;
  logic signed [DW-1:0]    cur, nxt;
  logic                    nxt_valid;
  logic [CW-1:0]           cnt;
  logic                    boundary;
  logic signed [QBITS+1:0] lvl;
  logic signed [EW-1:0]    fb, sum1, sum2;
  logic                    clip1, clip2;
  logic [QBITS-1:0]        q;

  function automatic logic out_of_range(input logic signed [EW-1:0] x);
    return (x > EW'(IMAX)) || (x < EW'(IMIN));
  endfunction

  assign in_ready = ~nxt_valid;
  assign boundary = (cnt == CW'(OSR - 1));

  always_comb begin
    // Feedback level 2*code+1-L is always odd; FS/L is a power of two so the
    // scaling is a plain shift.
    lvl  = $signed({1'b0, code, 1'b1}) - (QBITS+2)'(L);
    fb   = EW'(lvl) <<< (FSL - QBITS);

    sum1  = EW'(i1) + EW'(cur) - fb;
    clip1 = out_of_range(sum1);
    i1n   = clip1 ? (sum1[EW-1] ? IMIN : IMAX) : sum1[IW-1:0];

    sum2  = EW'(i2) + EW'(i1n) - fb;
    clip2 = 1'b0;
    i2n   = '0;
    if (ORDER == 2) begin
      clip2 = out_of_range(sum2);
      i2n   = clip2 ? (sum2[EW-1] ? IMIN : IMAX) : sum2[IW-1:0];
    end

    s  = (ORDER == 2) ? i2n : i1n;
    // Floor shift then recentre; clamp to the code range.
    qf = (s >>> QSH) + IW'(L / 2);
    if (qf < 0)
      q = '0;
    else if (qf > IW'(L - 1))
      q = QBITS'(L - 1);
    else
      q = qf[QBITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i1         <= '0;
      i2         <= '0;
      cur        <= '0;
      nxt        <= '0;
      nxt_valid  <= 1'b0;
      cnt        <= '0;
      code       <= QBITS'(L / 2);
      code_valid <= 1'b0;
      sat_flag   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      code_valid <= ce;

      // Clear first so a same-cycle set below takes priority.
      if (clr_flags) begin
        sat_flag <= 1'b0;
        underrun <= 1'b0;
      end

      if (in_valid && in_ready) begin
        nxt       <= in_data;
        nxt_valid <= 1'b1;
      end

      if (ce) begin
        i1   <= i1n;
        i2   <= i2n;
        code <= q;
        cnt  <= boundary ? '0 : cnt + 1'b1;
        if (clip1 || clip2)
          sat_flag <= 1'b1;
        // The loop above used the old cur; the new one applies from the next tick.
        // An accept in an underrun cycle only fills nxt (in_ready was high,
        // so nxt_valid was 0 and nothing is transferred).
        if (boundary) begin
          if (nxt_valid) begin
            cur       <= nxt;
            nxt_valid <= 1'b0;
          end else begin
            underrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dsm_mod_param.sv
`timescale 1ns/1ps
module tb_dsm_mod_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Instance A: defaults (ORDER=1, QBITS=1, OSR=4)
  logic        a_rst = 1'b0, a_ce = 1'b0, a_valid = 1'b0, a_clr = 1'b0;
  logic [19:0] a_data = '0;
  logic        a_ready, a_cv, a_sat, a_und;
  logic [0:0]  a_code;
  // Instance B: OSR_LOG2=6
  logic        b_rst = 1'b0, b_ce = 1'b0, b_valid = 1'b0, b_clr = 1'b0;
  logic [19:0] b_data = '0;
  logic        b_ready, b_cv, b_sat, b_und;
  logic [0:0]  b_code;
  // Instance C: ORDER=2, IW=18
  logic        c_rst = 1'b0, c_ce = 1'b0, c_valid = 1'b0, c_clr = 1'b0;
  logic [19:0] c_data = '0;
  logic        c_ready, c_cv, c_sat, c_und;
  logic [0:0]  c_code;
  // Instance D: QBITS=2
  logic        d_rst = 1'b0, d_ce = 1'b0, d_valid = 1'b0, d_clr = 1'b0;
  logic [19:0] d_data = '0;
  logic        d_ready, d_cv, d_sat, d_und;
  logic [1:0]  d_code;

  dsm_mod_param u_a (
    .clk(clk), .reset(a_rst), .ce(a_ce), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .clr_flags(a_clr), .code(a_code), .code_valid(a_cv),
    .sat_flag(a_sat), .underrun(a_und));

  dsm_mod_param #(.OSR_LOG2(6)) u_b (
    .clk(clk), .reset(b_rst), .ce(b_ce), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .clr_flags(b_clr), .code(b_code), .code_valid(b_cv),
    .sat_flag(b_sat), .underrun(b_und));

  dsm_mod_param #(.ORDER(2), .IW(18)) u_c (
    .clk(clk), .reset(c_rst), .ce(c_ce), .in_data(c_data), .in_valid(c_valid),
    .in_ready(c_ready), .clr_flags(c_clr), .code(c_code), .code_valid(c_cv),
    .sat_flag(c_sat), .underrun(c_und));

  dsm_mod_param #(.QBITS(2)) u_d (
    .clk(clk), .reset(d_rst), .ce(d_ce), .in_data(d_data), .in_valid(d_valid),
    .in_ready(d_ready), .clr_flags(d_clr), .code(d_code), .code_valid(d_cv),
    .sat_flag(d_sat), .underrun(d_und));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1; b_rst = 1; c_rst = 1; d_rst = 1;
    cyc(); cyc();
    n_total++; if (a_code !== 1'b1) $display("FAIL reset_code: got %0d want 1", a_code); else n_pass++;
    n_total++; if (a_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", a_ready); else n_pass++;
    n_total++; if (a_cv !== 1'b0) $display("FAIL reset_code_valid: got %0b want 0", a_cv); else n_pass++;
    n_total++; if (a_sat !== 1'b0) $display("FAIL reset_sat: got %0b want 0", a_sat); else n_pass++;
    n_total++; if (a_und !== 1'b0) $display("FAIL reset_underrun: got %0b want 0", a_und); else n_pass++;
    n_total++; if (d_code !== 2'd2) $display("FAIL reset_code_q2: got %0d want 2", d_code); else n_pass++;
    a_rst = 0; b_rst = 0; c_rst = 0; d_rst = 0;
  endtask

  task automatic test_order1_zero();
    int                exp_code_q[$];
    logic signed [23:0] exp_i1_q[$];
    int                ec;
    logic signed [23:0] ei;
    a_ce = 1;
    for (int k = 1; k <= 8; k++) begin
      exp_code_q.push_back((k % 2 == 1) ? 0 : 1);
      exp_i1_q.push_back((k % 2 == 1) ? -24'sd16384 : 24'sd0);
      cyc();
      n_total++; if (a_cv !== 1'b1) $display("FAIL o1_code_valid t%0d: got %0b want 1", k, a_cv); else n_pass++;
      if (a_cv === 1'b1) begin
        ec = exp_code_q.pop_front();
        ei = exp_i1_q.pop_front();
        n_total++; if (a_code !== ec[0:0]) $display("FAIL o1_code t%0d: got %0d want %0d", k, a_code, ec); else n_pass++;
        n_total++; if (u_a.i1 !== ei) $display("FAIL o1_i1 t%0d: got %0h want %0h", k, u_a.i1, ei); else n_pass++;
      end
    end
    a_ce = 0;
  endtask

  task automatic test_handshake();
    logic [19:0] sq[$];
    logic [19:0] es;
    a_rst = 1; cyc(); a_rst = 0;
    a_ce = 1; a_valid = 1; a_data = 20'h01234; sq.push_back(20'h01234);
    cyc();                                  // tick 1: A accepted
    n_total++; if (a_ready !== 1'b0) $display("FAIL hs_busy_after_a: got %0b want 0", a_ready); else n_pass++;
    a_data = 20'h00abc;
    cyc(); cyc();                           // ticks 2,3
    n_total++; if (a_ready !== 1'b0) $display("FAIL hs_busy_t3: got %0b want 0", a_ready); else n_pass++;
    cyc();                                  // tick 4: boundary
    n_total++; if (a_ready !== 1'b1) $display("FAIL hs_free_t4: got %0b want 1", a_ready); else n_pass++;
    es = sq.pop_front();
    n_total++; if (u_a.cur !== es) $display("FAIL hs_cur_a: got %0h want %0h", u_a.cur, es); else n_pass++;
    sq.push_back(20'h00abc);
    cyc();                                  // tick 5: B accepted
    n_total++; if (a_ready !== 1'b0) $display("FAIL hs_b_accept: got %0b want 0", a_ready); else n_pass++;
    a_valid = 0;
    cyc(); cyc(); cyc();                    // tick 8: boundary, B transferred
    es = sq.pop_front();
    n_total++; if (u_a.cur !== es) $display("FAIL hs_cur_b: got %0h want %0h", u_a.cur, es); else n_pass++;
    n_total++; if (a_und !== 1'b0) $display("FAIL hs_no_underrun: got %0b want 0", a_und); else n_pass++;
    cyc(); cyc(); cyc();                    // ticks 9..11
    n_total++; if (a_und !== 1'b0) $display("FAIL hs_und_early: got %0b want 0", a_und); else n_pass++;
    cyc();                                  // tick 12: boundary, empty buffer
    n_total++; if (a_und !== 1'b1) $display("FAIL hs_underrun: got %0b want 1", a_und); else n_pass++;
    a_clr = 1; cyc(); a_clr = 0;
    n_total++; if (a_und !== 1'b0) $display("FAIL hs_clr: got %0b want 0", a_und); else n_pass++;
    a_ce = 0;
  endtask

  task automatic test_density();
    int ones = 0;
    int seen = 0;
    b_ce = 1; b_valid = 1; b_data = 20'h02000;
    for (int k = 1; k <= 64; k++) cyc();    // tick 64 loads 0x2000
    for (int k = 1; k <= 64; k++) begin
      cyc();
      if (b_cv === 1'b1) begin
        seen++;
        if (b_code === 1'b1) ones++;
      end
    end
    n_total++; if (seen != 64) $display("FAIL dens_valid: got %0d want 64", seen); else n_pass++;
    n_total++; if (ones < 47 || ones > 49) $display("FAIL dens_ones: got %0d want 48+-1", ones); else n_pass++;
    n_total++; if (b_und !== 1'b0) $display("FAIL dens_underrun: got %0b want 0", b_und); else n_pass++;
    b_ce = 0; b_valid = 0;
  endtask

  task automatic test_saturation();
    int first = 0;
    logic signed [17:0] i2_at = '0;
    c_ce = 1; c_valid = 1; c_data = 20'h07fff;
    for (int t = 1; t <= 20; t++) begin
      cyc();
      if (c_sat === 1'b1 && first == 0) begin
        first = t;
        i2_at = u_c.i2;
      end
    end
    n_total++; if (first == 0 || first > 20) $display("FAIL sat_within: got tick %0d want <=20", first); else n_pass++;
    n_total++; if (first != 7) $display("FAIL sat_tick: got %0d want 7", first); else n_pass++;
    n_total++; if (i2_at !== 18'sh1ffff) $display("FAIL sat_i2_clip: got %0h want 1ffff", i2_at); else n_pass++;
    n_total++; if (u_c.i1 !== 18'sh1ffff) $display("FAIL sat_i1_clip: got %0h want 1ffff", u_c.i1); else n_pass++;
    c_clr = 1; cyc(); c_clr = 0;            // clip and clear together
    n_total++; if (c_sat !== 1'b1) $display("FAIL sat_set_wins: got %0b want 1", c_sat); else n_pass++;
    c_ce = 0;
    c_clr = 1; cyc(); c_clr = 0;
    n_total++; if (c_sat !== 1'b0) $display("FAIL sat_clr: got %0b want 0", c_sat); else n_pass++;
    c_valid = 0;
  endtask

  task automatic test_multibit_reset();
    int                exp_code_q[$];
    logic signed [23:0] exp_i1_q[$];
    int                ec;
    logic signed [23:0] ei;
    d_ce = 1;
    for (int k = 1; k <= 6; k++) begin
      exp_code_q.push_back((k % 2 == 1) ? 1 : 2);
      exp_i1_q.push_back((k % 2 == 1) ? -24'sd8192 : 24'sd0);
      cyc();
      if (d_cv === 1'b1) begin
        ec = exp_code_q.pop_front();
        ei = exp_i1_q.pop_front();
        n_total++; if (d_code !== ec[1:0]) $display("FAIL mb_code t%0d: got %0d want %0d", k, d_code, ec); else n_pass++;
        n_total++; if (u_d.i1 !== ei) $display("FAIL mb_i1 t%0d: got %0h want %0h", k, u_d.i1, ei); else n_pass++;
      end else begin
        n_total++; $display("FAIL mb_code_valid t%0d: got 0 want 1", k);
      end
    end
    d_valid = 1; d_data = 20'h01111;
    cyc();
    n_total++; if (d_ready !== 1'b0) $display("FAIL mb_loaded: got %0b want 0", d_ready); else n_pass++;
    d_rst = 1; cyc(); d_rst = 0;            // ce and in_valid still high
    n_total++; if (d_code !== 2'd2) $display("FAIL mr_code: got %0d want 2", d_code); else n_pass++;
    n_total++; if (u_d.i1 !== 24'sd0) $display("FAIL mr_i1: got %0h want 0", u_d.i1); else n_pass++;
    n_total++; if (d_ready !== 1'b1) $display("FAIL mr_ready: got %0b want 1", d_ready); else n_pass++;
    n_total++; if (d_cv !== 1'b0) $display("FAIL mr_code_valid: got %0b want 0", d_cv); else n_pass++;
    n_total++; if (d_und !== 1'b0) $display("FAIL mr_underrun: got %0b want 0", d_und); else n_pass++;
    d_valid = 0; d_ce = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cyc();
    test_reset();
    test_order1_zero();
    test_handshake();
    test_density();
    test_saturation();
    test_multibit_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
